cuenta_param_estados: RTL and testbench
=======================================

Name: cuenta_param_estados

Overview:
Parametrised up/down counter with explicit control-unit FSM, successor of the fixed 3-bit start/fin counter.
- On start, latches a target value and direction, then counts one step per enabled clock until the bound is reached, and signals fin.
- Adds count enable (stall), abort, busy flag and a saturating cycle counter for datapath sequencing in the practice designs.

Parameters:
WV, 3, width of valor (target value)
WC, WV+2, width of ciclos (total cycles spent in CUENTA, saturating)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a count (sampled in INICIO or FIN)
modo  in  1  0 = count up 0..valor, 1 = count down valor..0 (latched on start)
en  in  1  count enable; 0 stalls in CUENTA
abort  in  1  cancel current count, return to INICIO
valor  in  WV  target/bound (latched on start)
cuenta  out  WV  current count value
fin  out  1  high while in FIN (Moore)
ocupado  out  1  high while in CUENTA (Moore)
ciclos  out  WC  clocks spent in CUENTA for the current run, saturates at all-ones

Behaviour:
- Reset: async, immediate. State INICIO; cuenta=0, ciclos=0, fin=0, ocupado=0; latched limite=0, modo_r=0. Reset mid-count discards everything.
- States: INICIO, CUENTA, FIN; encoding is local to the block; outputs are registered or state-decoded (no combinational path from inputs to outputs).
- INICIO:
  - start=1 at an edge: limite<=valor, modo_r<=modo, ciclos<=0.
  - cuenta <= 0 if modo=0, else valor.
  - If valor==0, next state is FIN with cuenta=0; otherwise CUENTA.
  - start=0: hold all registers.
- CUENTA, priority abort > en:
  - abort=1: next INICIO; cuenta and ciclos hold; fin stays 0.
  - Otherwise, ciclos <= ciclos+1 unless all-ones (saturate, no wrap).
  - en=1, modo_r=0: cuenta<=cuenta+1; next FIN when cuenta+1==limite.
  - en=1, modo_r=1: cuenta<=cuenta-1; next FIN when cuenta-1==0.
  - en=0: cuenta holds, state holds.
  - start and valor changes are ignored.
- FIN:
  - fin=1; cuenta and ciclos hold the final values.
  - abort=1: INICIO (priority over start).
  - Else start=1: restart exactly as from INICIO (same-edge load, no dead cycle).
  - Else stay.
- Latency: with en held high, fin rises valor edges after the start-capture edge. ciclos then equals valor. Each stall cycle adds 1 to both fin latency and ciclos.
- Arithmetic: cuenta never wraps, because terminal detection occurs at the bound; limite=2^WV-1 reaches all-ones cleanly.
- ciclos is internal counter width WC; saturation is the only overflow behaviour.
- start held high continuously in FIN restarts every completion.

Decomposition:
- Shared package/header: state encoding constants (INICIO, CUENTA, FIN) and MODO_ARRIBA=0, MODO_ABAJO=1, for reuse by future control units and benches.
- One natural sub-module: contador_sat (WC-bit saturating counter with clear and enable) for ciclos.
- FSM and up/down datapath stay in the top module.

Test Plan:
- Reset then start=1 for one edge, modo=0, valor=5, en=1 -> cuenta 0,1,2,3,4,5; fin=1 on the 5th edge after capture; ciclos=5; ocupado low once fin is high.
- modo=1, valor=7, en=1 -> cuenta 7,6,...,0; fin after 7 edges; then start with valor=0 from FIN -> immediate FIN with cuenta=0, ciclos=0.
- modo=0, valor=3, en toggling 1,0,0,1,1 -> cuenta 0,1,1,1,2,3; fin after 5 edges; ciclos=5.
- abort=1 with en=1 while cuenta=2 (valor=6) -> next state INICIO, cuenta stays 2, fin never asserts. Also abort+start together in FIN -> INICIO, no reload.
- reset asserted asynchronously mid-count (between edges, cuenta=4) -> outputs zero immediately; after release, start with valor=2 counts normally.
- WV=3, WC=2, modo=0, valor=7, en low for 4 cycles then high -> ciclos saturates at 3, cuenta reaches 7, fin asserts; no wrap observed.

Source files
------------

// File: rtl/cuenta_param_estados_pkg.sv
// Shared definitions for cuenta_param_estados and for future control units and benches.
// Holds the control-unit state encoding and the names of the count directions.
package cuenta_param_estados_pkg;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    CUENTA = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic MODO_ARRIBA = 1'b0;
  localparam logic MODO_ABAJO  = 1'b1;

endpackage

// File: rtl/cuenta_param_estados_if.sv
// Control/status bundle of the up/down counter.
// The master drives the commands and the target value; the slave returns the count and status.
interface cuenta_param_estados_if #(
  parameter int WV = 3,
  parameter int WC = WV + 2
);
  logic          start;
  logic          modo;
  logic          en;
  logic          abort;
  logic [WV-1:0] valor;
  logic [WV-1:0] cuenta;
  logic          fin;
  logic          ocupado;
  logic [WC-1:0] ciclos;

  modport master (
    output start, modo, en, abort, valor,
    input  cuenta, fin, ocupado, ciclos
  );

  modport slave (
    input  start, modo, en, abort, valor,
    output cuenta, fin, ocupado, ciclos
  );
endinterface

// File: rtl/cuenta_param_estados_contador_sat.sv
// W-bit saturating counter with synchronous clear.
// Once it reaches all-ones it holds there; it never wraps.
module contador_sat #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // NOTE: sequential state is always assigned with <=, so every register
  // samples pre-edge values regardless of the order of the statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 q <= '0;
    else if (clr)              q <= '0;
    else if (en && (q != '1))  q <= q + W'(1);
  end

endmodule

// File: rtl/cuenta_param_estados.sv
// Parametrised up/down counter driven by a three-state control unit (INICIO/CUENTA/FIN).
// On start it latches valor and modo, then counts to the bound and holds fin.
module cuenta_param_estados
  import cuenta_param_estados_pkg::*;
#(
  parameter int WV = 3,
  parameter int WC = WV + 2
) (
  input logic                    clk,
  input logic                    reset,
  cuenta_param_estados_if.slave  bus
);

  estado_t       estado, estado_sig;
  logic [WV-1:0] cuenta_r, cuenta_sig, limite;
  logic          modo_r;
  logic          carga, avanza, terminal, cuenta_ciclo;
  logic          fin_q, ocupado_q;
  logic [WC-1:0] ciclos_q;

  // A load happens from INICIO, or from FIN when no abort competes with start.
  assign carga        = bus.start && ((estado == INICIO) || ((estado == FIN) && !bus.abort));
  assign cuenta_ciclo = (estado == CUENTA) && !bus.abort;
  assign avanza       = cuenta_ciclo && bus.en;
  assign cuenta_sig   = (modo_r == MODO_ABAJO) ? cuenta_r - WV'(1) : cuenta_r + WV'(1);
  assign terminal     = (cuenta_sig == ((modo_r == MODO_ABAJO) ? '0 : limite));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= INICIO;
    else       estado <= estado_sig;
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      INICIO: if (bus.start) estado_sig = (bus.valor == '0) ? FIN : CUENTA;
      CUENTA: begin
        if (bus.abort)                estado_sig = INICIO;
        else if (bus.en && terminal)  estado_sig = FIN;
      end
      FIN: begin
        if (bus.abort)      estado_sig = INICIO;
        else if (bus.start) estado_sig = (bus.valor == '0) ? FIN : CUENTA;
      end
      default: estado_sig = INICIO;
    endcase
  end

  always_comb begin
    fin_q     = (estado == FIN);
    ocupado_q = (estado == CUENTA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_r <= '0;
      limite   <= '0;
      modo_r   <= MODO_ARRIBA;
    end else if (carga) begin
      limite   <= bus.valor;
      modo_r   <= bus.modo;
      cuenta_r <= (bus.modo == MODO_ABAJO) ? bus.valor : '0;
    end else if (avanza) begin
      cuenta_r <= cuenta_sig;
    end
  end

  contador_sat #(.W(WC)) u_ciclos (
    .clk   (clk),
    .reset (reset),
    .clr   (carga),
    .en    (cuenta_ciclo),
    .q     (ciclos_q)
  );

  assign bus.cuenta  = cuenta_r;
  assign bus.fin     = fin_q;
  assign bus.ocupado = ocupado_q;
  assign bus.ciclos  = ciclos_q;

endmodule

// File: tb/tb_cuenta_param_estados.sv
// Bench for cuenta_param_estados: two instances (WC=5 and WC=2) share one stimulus
// and are compared every edge against a remaining-steps reference model.
module tb_cuenta_param_estados;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cuenta_param_estados_if #(.WV(3), .WC(5)) if_a ();
  cuenta_param_estados_if #(.WV(3), .WC(2)) if_s ();

  cuenta_param_estados #(.WV(3), .WC(5)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  cuenta_param_estados #(.WV(3), .WC(2)) dut_s (.clk(clk), .reset(reset), .bus(if_s));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a run is described by its bound, direction and the
  // enabled steps still missing; the count value follows from those.
  bit m_act, m_fin, m_modo;
  int m_rest, m_lim, m_raw;

  task automatic modelo_reset();
    m_act = 0; m_fin = 0; m_modo = 0;
    m_rest = 0; m_lim = 0; m_raw = 0;
  endtask

  task automatic modelo_flanco(input bit st, input bit md, input bit e, input bit ab, input int v);
    if (m_act) begin
      if (ab) m_act = 0;
      else begin
        m_raw++;
        if (e) begin
          m_rest--;
          if (m_rest == 0) begin m_act = 0; m_fin = 1; end
        end
      end
    end else if (m_fin && ab) begin
      m_fin = 0;
    end else if (st) begin
      m_lim = v; m_modo = md; m_rest = v; m_raw = 0;
      m_fin = (v == 0);
      m_act = (v != 0);
    end
  endtask

  function automatic logic [11:0] observado();
    return {if_a.cuenta, if_a.fin, if_a.ocupado, if_a.ciclos, if_s.ciclos};
  endfunction

  function automatic logic [11:0] esperado();
    logic [2:0] c;
    logic [4:0] ca;
    logic [1:0] cs;
    c  = m_modo ? 3'(m_rest) : 3'(m_lim - m_rest);
    ca = 5'((m_raw > 31) ? 31 : m_raw);
    cs = 2'((m_raw > 3) ? 3 : m_raw);
    return {c, m_fin, m_act, ca, cs};
  endfunction

  task automatic drive(input bit st, input bit md, input bit e, input bit ab, input int v);
    if_a.start = st; if_a.modo = md; if_a.en = e; if_a.abort = ab; if_a.valor = 3'(v);
    if_s.start = st; if_s.modo = md; if_s.en = e; if_s.abort = ab; if_s.valor = 3'(v);
  endtask

  // One clock edge: inputs set off-edge, model advanced at the edge, outputs settle by +1.
  task automatic paso(input bit st, input bit md, input bit e, input bit ab, input int v);
    drive(st, md, e, ab, v);
    @(posedge clk);
    modelo_flanco(st, md, e, ab, v);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    modelo_reset();
    #12;
    n_cmp++;
    if (observado() !== esperado() || observado() !== 12'h000) begin
      n_err++; $display("FAIL reset: got=%h exp=%h", observado(), esperado());
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      paso(0, 0, 1, 1, 5);
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL reset_idle[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
  endtask

  task automatic test_arriba();
    paso(1, 0, 1, 0, 5);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL arriba[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
      if (i < 5) paso(0, 0, 1, 0, 2);
    end
    n_cmp++;
    if ({if_a.cuenta, if_a.fin, if_a.ocupado, if_a.ciclos} !== {3'd5, 1'b1, 1'b0, 5'd5}) begin
      n_err++; $display("FAIL arriba_fin: got cuenta=%0d fin=%b ocupado=%b ciclos=%0d exp 5/1/0/5",
                        if_a.cuenta, if_a.fin, if_a.ocupado, if_a.ciclos);
    end
  endtask

  task automatic test_abajo_y_cero();
    paso(1, 1, 1, 0, 7);
    for (int i = 0; i < 7; i++) begin
      paso(0, 0, 1, 0, 3);
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL abajo[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
    paso(1, 0, 1, 0, 0);
    n_cmp++;
    if (observado() !== esperado() || {if_a.cuenta, if_a.fin, if_a.ciclos} !== {3'd0, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL valor_cero: got=%h exp=%h", observado(), esperado());
    end
  endtask

  task automatic test_stall();
    bit patron [5] = '{1, 0, 0, 1, 1};
    paso(1, 0, 1, 0, 3);
    foreach (patron[i]) begin
      paso(0, 0, patron[i], 0, 6);
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL stall[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
    n_cmp++;
    if ({if_a.cuenta, if_a.fin, if_a.ciclos} !== {3'd3, 1'b1, 5'd5}) begin
      n_err++; $display("FAIL stall_fin: got cuenta=%0d fin=%b ciclos=%0d exp 3/1/5",
                        if_a.cuenta, if_a.fin, if_a.ciclos);
    end
  endtask

  task automatic test_abort();
    paso(1, 0, 1, 0, 6);
    paso(0, 0, 1, 0, 0);
    paso(0, 0, 1, 0, 0);
    paso(1, 1, 1, 1, 4);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (observado() !== esperado() || {if_a.cuenta, if_a.fin, if_a.ocupado} !== {3'd2, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL abort_cuenta[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
      paso(0, 0, 1, 1, 0);
    end
    paso(1, 0, 1, 0, 1);
    paso(0, 0, 1, 0, 0);
    paso(1, 1, 1, 1, 5);
    n_cmp++;
    if (observado() !== esperado() || {if_a.cuenta, if_a.fin, if_a.ocupado} !== {3'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL abort_start_fin: got=%h exp=%h", observado(), esperado());
    end
  endtask

  task automatic test_reset_async();
    paso(1, 0, 1, 0, 7);
    for (int i = 0; i < 4; i++) paso(0, 0, 1, 0, 0);
    #2 reset = 1'b1;
    #1 modelo_reset();
    n_cmp++;
    if (observado() !== esperado() || observado() !== 12'h000) begin
      n_err++; $display("FAIL reset_async: got=%h exp=%h", observado(), esperado());
    end
    @(negedge clk) reset = 1'b0;
    paso(1, 0, 1, 0, 2);
    for (int i = 0; i < 3; i++) begin
      paso(0, 0, 1, 0, 0);
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL post_reset[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
  endtask

  task automatic test_saturacion();
    paso(1, 0, 1, 0, 7);
    for (int i = 0; i < 11; i++) begin
      paso(0, 0, (i >= 4), 0, 1);
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL saturacion[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
    n_cmp++;
    if ({if_s.cuenta, if_s.fin, if_s.ciclos, if_a.ciclos} !== {3'd7, 1'b1, 2'd3, 5'd11}) begin
      n_err++; $display("FAIL saturacion_fin: got cuenta=%0d fin=%b ciclos_s=%0d ciclos_a=%0d exp 7/1/3/11",
                        if_s.cuenta, if_s.fin, if_s.ciclos, if_a.ciclos);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      paso(1, 1'($urandom_range(0, 1)), 1, 0, (i < 6) ? 2 : 1);
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL back_to_back[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
  endtask

  task automatic test_aleatorio();
    for (int i = 0; i < 400; i++) begin
      paso(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
      n_cmp++;
      if (observado() !== esperado()) begin
        n_err++; $display("FAIL aleatorio[%0d]: got=%h exp=%h", i, observado(), esperado());
      end
    end
  endtask

  initial begin
    test_reset();
    test_arriba();
    test_abajo_y_cero();
    test_stall();
    test_abort();
    test_reset_async();
    test_saturacion();
    test_back_to_back();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
